// File: rtl/mesh_pkg.sv
// Shared mesh definitions: packet/flit geometry defaults and the injector state encoding.
package mesh_pkg;

    localparam int DEF_PACKET_SIZE  = 32;
    localparam int DEF_FLIT_WIDTH   = 4;
    localparam int FLITS_PER_PACKET = DEF_PACKET_SIZE / DEF_FLIT_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } inj_state_e;

endpackage

// File: rtl/spike_fifo.sv
// Single-clock packet FIFO with full/empty flags; pushes while full and pops while empty are ignored.
module spike_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             neu_clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // NOTE: every signal written here gets a value before any condition, so no latch can be inferred.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge neu_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define what is valid.
    always_ff @(posedge neu_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/packet_injector.sv
// Buffers spike packets and serializes them MSB-nibble first onto a valid/ready flit port.
// Optional feature macro: INJECTOR_PARITY_EN appends an XOR parity flit to every packet.
module packet_injector
    import mesh_pkg::*;
#(
    parameter int PACKET_SIZE = DEF_PACKET_SIZE,
    parameter int FLIT_WIDTH  = DEF_FLIT_WIDTH,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   neu_clk,
    input  logic                   rst_n,
    input  logic                   write_req,
    input  logic [PACKET_SIZE-1:0] spike_packet,
    output logic                   fifo_full,
    output logic [FLIT_WIDTH-1:0]  flit_out,
    output logic                   flit_valid,
    input  logic                   flit_ready,
    output logic                   busy,
    output logic                   overflow
);

    localparam int DATA_FLITS = PACKET_SIZE / FLIT_WIDTH;
`ifdef INJECTOR_PARITY_EN
    localparam int N_FLITS = DATA_FLITS + 1;
`else
    localparam int N_FLITS = DATA_FLITS;
`endif
    localparam int SHIFT_W = N_FLITS * FLIT_WIDTH;
    localparam int CNT_W   = $clog2(N_FLITS + 1);

    inj_state_e             state_q, state_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   fifo_pop, fifo_empty;
    logic [PACKET_SIZE-1:0] fifo_rdata;
    logic [SHIFT_W-1:0]     load_val;
    logic                   last_flit;

    spike_fifo #(
        .WIDTH (PACKET_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .neu_clk (neu_clk),
        .rst_n   (rst_n),
        .push    (write_req),
        .wdata   (spike_packet),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef INJECTOR_PARITY_EN
    // Parity rides in the low nibble so it leaves the shift register after the data.
    logic [FLIT_WIDTH-1:0] parity;
    always_comb begin
        parity = '0;
        for (int i = 0; i < DATA_FLITS; i++) begin
            parity = parity ^ fifo_rdata[i*FLIT_WIDTH +: FLIT_WIDTH];
        end
        load_val = {fifo_rdata, parity};
    end
`else
    always_comb begin
        load_val = fifo_rdata;
    end
`endif

    assign last_flit  = (cnt_q == CNT_W'(N_FLITS - 1));
    assign flit_valid = (state_q == SEND);
    assign flit_out   = (state_q == SEND) ? shift_q[SHIFT_W-1 -: FLIT_WIDTH] : '0;
    assign busy       = (state_q == SEND) || !fifo_empty;
    assign overflow   = overflow_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q || (write_req && fifo_full);

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = load_val;
                    cnt_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (flit_ready) begin
                    shift_d = shift_q << FLIT_WIDTH;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_flit) begin
                        cnt_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = load_val;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge neu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
